// File: rtl/clock_set_pkg.sv
// rtl/clock_set_pkg.sv - mode encodings, field limits and digit positions for the time-set controller
package clock_set_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Index of the ones nibble of each field within bcd_out; tens sits one above.
    localparam int HOUR_NIB = 4;
    localparam int MIN_NIB  = 2;
    localparam int SEC_NIB  = 0;

    function automatic logic [5:0] field_mask(input logic [1:0] m, input logic ph);
        logic [5:0] mask;
        mask = 6'b000000;
        case (m)
            MODE_SET_HOUR: mask[HOUR_NIB +: 2] = {ph, ph};
            MODE_SET_MIN:  mask[MIN_NIB  +: 2] = {ph, ph};
            MODE_SET_SEC:  mask[SEC_NIB  +: 2] = {ph, ph};
            default:       mask = 6'b000000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// rtl/bcd_field_step.sv - one two-digit BCD field stepped up or down with wrap at 23 or 59
module bcd_field_step
    import clock_set_pkg::*;
(
    input  logic [7:0] field_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       is_hour_i,
    output logic [7:0] next_o,
    output logic       wrap_o
);

    logic [7:0] max_bcd;
    logic [3:0] tens;
    logic [3:0] ones;

    assign max_bcd = is_hour_i ? HOUR_MAX : MINSEC_MAX;
    assign tens    = field_i[7:4];
    assign ones    = field_i[3:0];

    // inc and dec together cancel; the field holds and no wrap is reported.
    always_comb begin
        next_o = field_i;
        wrap_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (field_i == max_bcd) begin
                next_o = 8'h00;
                wrap_o = 1'b1;
            end else if (ones == 4'd9) begin
                next_o = {tens + 4'd1, 4'd0};
            end else begin
                next_o = {tens, ones + 4'd1};
            end
        end else if (dec_i && !inc_i) begin
            if (field_i == 8'h00) begin
                next_o = max_bcd;
                wrap_o = 1'b1;
            end else if (ones == 4'd0) begin
                next_o = {tens - 4'd1, 4'd9};
            end else begin
                next_o = {tens, ones - 4'd1};
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - HH:MM:SS digit registers with run/set mode sequencing and field blink
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int BLINK_HALF = 12_500_000,
    parameter int CNT_W      = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        key_dec,
    output logic [23:0] bcd_out,
    output logic [5:0]  blank_mask,
    output logic [1:0]  mode
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [1:0]       mode_q, mode_d;
    logic [7:0]       hour_q, hour_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       sec_q, sec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [5:0]       mask_q, mask_d;

    logic run;
    logic any_key;
    logic adj_inc;
    logic adj_dec;
    logic sec_inc, sec_dec, sec_wrap;
    logic min_inc, min_dec, min_wrap;
    logic hour_inc, hour_dec, hour_wrap_unused;

    assign run     = (mode_q == MODE_RUN);
    assign any_key = key_mode | key_inc | key_dec;
    // A mode press swallows any inc/dec in the same cycle.
    assign adj_inc = key_inc & ~key_dec & ~key_mode;
    assign adj_dec = key_dec & ~key_inc & ~key_mode;

    assign mode_d = key_mode ? mode_q + 2'd1 : mode_q;

    // In RUN the wrap flags form the seconds->minutes->hours carry chain.
    assign sec_inc  = run ? tick_1hz : (mode_q == MODE_SET_SEC) & adj_inc;
    assign sec_dec  = ~run & (mode_q == MODE_SET_SEC) & adj_dec;
    assign min_inc  = run ? sec_wrap : (mode_q == MODE_SET_MIN) & adj_inc;
    assign min_dec  = ~run & (mode_q == MODE_SET_MIN) & adj_dec;
    assign hour_inc = run ? min_wrap : (mode_q == MODE_SET_HOUR) & adj_inc;
    assign hour_dec = ~run & (mode_q == MODE_SET_HOUR) & adj_dec;

    bcd_field_step u_sec_step (
        .field_i   (sec_q),
        .inc_i     (sec_inc),
        .dec_i     (sec_dec),
        .is_hour_i (1'b0),
        .next_o    (sec_d),
        .wrap_o    (sec_wrap)
    );

    bcd_field_step u_min_step (
        .field_i   (min_q),
        .inc_i     (min_inc),
        .dec_i     (min_dec),
        .is_hour_i (1'b0),
        .next_o    (min_d),
        .wrap_o    (min_wrap)
    );

    bcd_field_step u_hour_step (
        .field_i   (hour_q),
        .inc_i     (hour_inc),
        .dec_i     (hour_dec),
        .is_hour_i (1'b1),
        .next_o    (hour_d),
        .wrap_o    (hour_wrap_unused)
    );

    // Any key press restarts the visible half so the field is steady right after an edit.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (any_key || run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    assign mask_d = field_mask(mode_d, phase_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_RUN;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            mask_q  <= 6'b000000;
        end else begin
            mode_q  <= mode_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mask_q  <= mask_d;
        end
    end

    assign bcd_out    = {hour_q, min_q, sec_q};
    assign blank_mask = mask_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        key_mode = 1'b0;
    logic        key_inc = 1'b0;
    logic        key_dec = 1'b0;
    logic [23:0] bcd_out;
    logic [5:0]  blank_mask;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;

    clock_set_ctrl #(
        .BLINK_HALF (4),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .key_mode   (key_mode),
        .key_inc    (key_inc),
        .key_dec    (key_dec),
        .bcd_out    (bcd_out),
        .blank_mask (blank_mask),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the update visible.
    task automatic pulse(input logic m, input logic i, input logic d, input logic t);
        key_mode = m;
        key_inc  = i;
        key_dec  = d;
        tick_1hz = t;
        @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_mask;
        int h;

        repeat (3) @(negedge clk);
        chk("reset_bcd", 32'(bcd_out), 32'h000000);
        chk("reset_mask", 32'(blank_mask), 32'h0);
        chk("reset_mode", 32'(mode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload 23:59:58 through the set modes, then roll over.
        pulse(1, 0, 0, 0);
        chk("enter_set_hour", 32'(mode), 32'd1);
        pulse(0, 0, 1, 0);
        chk("hour_dec_wrap", 32'(bcd_out), 32'h230000);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("min_dec_wrap", 32'(bcd_out), 32'h235900);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        chk("sec_preload", 32'(bcd_out), 32'h235958);
        pulse(1, 0, 0, 0);
        chk("back_to_run", 32'(mode), 32'd0);
        chk("run_mask", 32'(blank_mask), 32'h0);
        pulse(0, 0, 0, 1);
        chk("tick_235959", 32'(bcd_out), 32'h235959);
        pulse(0, 0, 0, 1);
        chk("rollover", 32'(bcd_out), 32'h000000);
        chk("rollover_mode", 32'(mode), 32'd0);
        chk("rollover_mask", 32'(blank_mask), 32'h0);

        // Hour field walks 01..23 then wraps to 00.
        pulse(1, 0, 0, 0);
        for (int i = 1; i <= 24; i++) begin
            pulse(0, 1, 0, 0);
            h = i % 24;
            chk("hour_inc_walk", 32'(bcd_out), 32'(((h / 10) * 16 + (h % 10)) << 16));
        end
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        chk("min_dec_no_borrow", 32'(bcd_out), 32'h005900);

        // Time is paused in a set mode.
        repeat (5) pulse(0, 0, 0, 1);
        chk("pause_ticks", 32'(bcd_out), 32'h005900);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        chk("run_tick_after_pause", 32'(bcd_out), 32'h005901);

        // Blink in SET_SEC: 4 visible, 4 blank, repeating.
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        chk("set_sec_mode", 32'(mode), 32'd3);
        for (int k = 0; k < 22; k++) begin
            exp_mask = ((k / 4) % 2 == 1) ? 6'b000011 : 6'b000000;
            chk("blink_cycle", 32'(blank_mask), 32'(exp_mask));
            if (k < 21) @(negedge clk);
        end
        pulse(0, 1, 0, 0);
        chk("inc_sec", 32'(bcd_out), 32'h005902);
        for (int j = 0; j < 8; j++) begin
            exp_mask = (j >= 4) ? 6'b000011 : 6'b000000;
            chk("blink_restart", 32'(blank_mask), 32'(exp_mask));
            @(negedge clk);
        end

        // Simultaneous events.
        pulse(0, 1, 1, 0);
        chk("inc_dec_cancel", 32'(bcd_out), 32'h005902);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        chk("mode_beats_inc_mode", 32'(mode), 32'd2);
        chk("mode_beats_inc_bcd", 32'(bcd_out), 32'h005902);
        pulse(0, 1, 0, 0);
        chk("min_inc_no_carry", 32'(bcd_out), 32'h000002);
        pulse(1, 0, 0, 0);
        repeat (3) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        chk("run_at_000005", 32'(bcd_out), 32'h000005);
        pulse(1, 0, 0, 1);
        chk("mode_tick_bcd", 32'(bcd_out), 32'h000006);
        chk("mode_tick_mode", 32'(mode), 32'd1);

        // Build 12:34:56 in SET_MIN, then reset between edges.
        repeat (12) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (34) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (50) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        chk("preset_bcd", 32'(bcd_out), 32'h123456);
        chk("preset_mode", 32'(mode), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(bcd_out), 32'h000000);
        chk("async_rst_mode", 32'(mode), 32'd0);
        chk("async_rst_mask", 32'(blank_mask), 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_hold_bcd", 32'(bcd_out), 32'h000000);
        chk("rst_hold_mode", 32'(mode), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_bcd", 32'(bcd_out), 32'h000000);
        chk("post_rst_mode", 32'(mode), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
